edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel dual-edge event scheduler. Detects rising and falling edges on `N_CH` synchronous single-bit inputs, queues at most one event per channel, and serialises the events onto a single valid/ready output stream using a round-robin arbiter. Downstream event consumers such as interrupt or logging blocks use it, so they do not each need their own per-signal edge detector.

## Interface
Parameters:
- `N_CH`, 4, number of input channels (2..16)
- `CH_W`, 2, channel-index width, equal to clog2(`N_CH`)

Ports:
- `clk` input 1: single clock; all logic on its rising edge
- `rst` input 1: reset, asynchronous and active-high
- `din` input `N_CH`: monitored signals, already synchronous to `clk`
- `ch_en` input `N_CH`: per-channel enable
- `ovf_clr` input `N_CH`: per-channel clear pulse for `ovf`
- `ev_valid` output 1: output event present
- `ev_ready` input 1: consumer accepts the event
- `ev_ch` output `CH_W`: channel index of the event
- `ev_rise` output 1: 1 = rising edge, 0 = falling edge
- `ovf` output `N_CH`: sticky flag, set when an event on that channel was dropped

## Operation
- **Edge detect**
  - `din_q` registers `din` every cycle.
  - `edge[i] = din[i] ^ din_q[i]`, with type `din[i]`.
  - Events are suppressed while `armed=0`.
- **Arming**
  - `armed` is reset to 0 and sets to 1 on the first clock after reset release.
  - This prevents spurious edges from the reset value of `din_q`.
- **Per-channel pending slot**
  - Each channel holds `pend_v[i]` and `pend_rise[i]`.
  - An edge on an enabled channel with an empty slot, or with a slot being granted in the same cycle, loads the slot.
  - An edge with the slot full and not granted is dropped and sets `ovf[i]`. The older event is kept.
- **Enable**
  - `ch_en[i]=0` clears `pend_v[i]` and ignores edges.
  - `din_q[i]` still tracks `din[i]`, so re-enabling produces no stale edge.
- **Overflow clear**
  - `ovf_clr[i]` clears `ovf[i]`.
  - A simultaneous drop on the same channel wins: `ovf[i]` stays 1.
- **Output register FSM**, two states:
  - `EMPTY`: `ev_valid=0`. If any slot is pending, load the arbiter winner into `ev_ch`/`ev_rise`, clear its slot, and go to `FULL`.
  - `FULL`: `ev_valid=1`. On `ev_ready=1`:
    - if another slot is pending, load the next winner and stay in `FULL`;
    - otherwise go to `EMPTY`.
  - On `ev_ready=0`, hold all outputs stable.
- **Arbitration**
  - Round-robin over `pend_v`; search starts at `last+1` and wraps modulo `N_CH`.
  - `last` updates to the granted channel on every load.
  - `last` resets to `N_CH-1`, so channel 0 has first priority.
- Only the slot actually loaded into the output register is cleared. A granted slot can reload from a same-cycle edge.

## Timing
- **Reset values:**
  - `ev_valid=0`, `ev_ch=0`, `ev_rise=0`, `ovf=0`
  - `pend_v=0`, `din_q=0`, `armed=0`, state `EMPTY`
- **Latency:**
  - A `din` change sampled at edge T loads the slot at T.
  - `ev_valid` rises after edge T+1 when the output is free, a latency of 2 cycles.
- **Throughput:** one event per cycle with `ev_ready` held high.
- **Fairness:** a continuously pending channel waits at most `N_CH-1` grants.
- **Handshake:**
  - `ev_valid` never drops without `ev_ready`.
  - `ev_ch` and `ev_rise` are stable while `ev_valid && !ev_ready`.
- **Reset mid-operation:** asynchronous return to the reset values. An in-flight event is lost and is not flagged.

## Structure
- Shared package/header `edge_arb_pkg`: FSM state encodings `ST_EMPTY=1'b0` and `ST_FULL=1'b1`, and the `CH_W` derivation function.
- Sub-module `edge_arb_rr`: a purely combinational round-robin picker.
  - Inputs: `req[N_CH]`, `last[CH_W]`.
  - Outputs: `gnt_v`, `gnt_idx[CH_W]`.
- Top level contains the edge detect, pending slots, `ovf`, FSM and `last` register.

## Test plan
- Reset released with `din=4'b1111` -> no events. Then `din[2]` 1→0 -> `ev_valid` 2 cycles later with `ev_ch=2`, `ev_rise=0`.
- `din` 0→1 on all 4 channels in the same cycle, `ev_ready=1` -> events `ch` 0,1,2,3 back-to-back on consecutive cycles, all with `ev_rise=1`.
- `ev_ready=0` for 5 cycles while channel 1 is pending -> outputs stable.
  - Meanwhile `din[1]` toggles twice -> `ovf[1]=1` and the original event is preserved.
  - `ovf_clr[1]` pulse then clears `ovf[1]`.
- Channels 0 and 3 pending continuously, `ev_ready=1` -> grants alternate 0,3,0,3. No starvation.
- `ch_en[2]=0` while channel 2 is pending -> pending dropped, no event and no `ovf`. Re-enable with `din[2]` unchanged -> no event.
- Assert `rst` while `ev_valid=1` -> `ev_valid=0` immediately (asynchronously). After release, no event appears until a new edge.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// Shared definitions for the edge event arbiter: output FSM encoding and
// the channel-index width helper.
package edge_arb_pkg;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Width of a channel index; never below one bit so two channels still index.
   function automatic int ch_w_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/edge_arb_rr.sv
// Combinational round-robin picker: first requester after `last`, wrapping
// modulo N_CH.
module edge_arb_rr
   import edge_arb_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = ch_w_of(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] last,
   output logic            gnt_v,
   output logic [CH_W-1:0] gnt_idx
);

   logic [CH_W:0] cand;

   // Walk the offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      gnt_v   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = N_CH; k >= 1; k--) begin
         cand = {1'b0, last} + (CH_W+1)'(k);
         if (cand >= (CH_W+1)'(N_CH)) begin
            cand = cand - (CH_W+1)'(N_CH);
         end
         if (req[cand[CH_W-1:0]]) begin
            gnt_v   = 1'b1;
            gnt_idx = cand[CH_W-1:0];
         end
      end
   end

endmodule

// File: rtl/edge_event_arbiter.sv
// Dual-edge event scheduler: per-channel edge detect into one-deep pending
// slots, serialised onto a valid/ready stream by a round-robin arbiter.
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = ch_w_of(N_CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] din,
   input  logic [N_CH-1:0] ch_en,
   input  logic [N_CH-1:0] ovf_clr,
   output logic            ev_valid,
   input  logic            ev_ready,
   output logic [CH_W-1:0] ev_ch,
   output logic            ev_rise,
   output logic [N_CH-1:0] ovf
);

   logic [N_CH-1:0] din_q;
   logic            armed;
   logic [N_CH-1:0] edge_ev;
   logic [N_CH-1:0] pend_v, pend_v_next;
   logic [N_CH-1:0] pend_rise, pend_rise_next;
   logic [N_CH-1:0] ovf_next;
   logic [N_CH-1:0] req, take, drop, slot_load;
   logic            gnt_v;
   logic [CH_W-1:0] gnt_idx;
   logic [CH_W-1:0] last_reg;
   logic            load_en;
   state_t          state_reg, state_next;

   // armed masks the first sampled cycle, where din_q still holds its reset value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         din_q <= '0;
         armed <= 1'b0;
      end else begin
         din_q <= din;
         armed <= 1'b1;
      end
   end

   assign edge_ev = (din ^ din_q) & {N_CH{armed}};
   assign req     = pend_v & ch_en;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_slot
         assign take[gi]      = load_en && (gnt_idx == CH_W'(gi));
         assign slot_load[gi] = ch_en[gi] && edge_ev[gi] && (!pend_v[gi] || take[gi]);
         assign drop[gi]      = ch_en[gi] && edge_ev[gi] && pend_v[gi] && !take[gi];
         assign pend_v_next[gi]    = ch_en[gi] && (slot_load[gi] || (pend_v[gi] && !take[gi]));
         assign pend_rise_next[gi] = slot_load[gi] ? din[gi] : pend_rise[gi];
         assign ovf_next[gi]       = drop[gi] || (ovf[gi] && !ovf_clr[gi]);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_v    <= '0;
         pend_rise <= '0;
         ovf       <= '0;
      end else begin
         pend_v    <= pend_v_next;
         pend_rise <= pend_rise_next;
         ovf       <= ovf_next;
      end
   end

   edge_arb_rr #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_rr (
      .req     (req),
      .last    (last_reg),
      .gnt_v   (gnt_v),
      .gnt_idx (gnt_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_EMPTY: if (gnt_v) state_next = ST_FULL;
         ST_FULL:  if (ev_ready && !gnt_v) state_next = ST_EMPTY;
         default:  state_next = ST_EMPTY;
      endcase
   end

   always_comb begin
      load_en  = gnt_v && ((state_reg == ST_EMPTY) || ev_ready);
      ev_valid = (state_reg == ST_FULL);
   end

   // last starts at N_CH-1 so the first search begins at channel 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev_ch    <= '0;
         ev_rise  <= 1'b0;
         last_reg <= CH_W'(N_CH - 1);
      end else if (load_en) begin
         ev_ch    <= gnt_idx;
         ev_rise  <= pend_rise[gnt_idx];
         last_reg <= gnt_idx;
      end
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed-vector bench for edge_event_arbiter: a per-cycle table of inputs
// and expected outputs, plus a hand-written asynchronous reset sequence.
module tb_edge_event_arbiter;

   localparam int N_CH = 4;
   localparam int CH_W = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N_CH-1:0] din = '1;
   logic [N_CH-1:0] ch_en = '1;
   logic [N_CH-1:0] ovf_clr = '0;
   logic            ev_ready = 1'b0;
   logic            ev_valid;
   logic [CH_W-1:0] ev_ch;
   logic            ev_rise;
   logic [N_CH-1:0] ovf;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] din;
      logic [3:0] en;
      logic [3:0] clr;
      logic       rdy;
      logic       v;
      logic [1:0] ch;
      logic       rise;
      logic [3:0] ovf;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   edge_event_arbiter #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .ch_en    (ch_en),
      .ovf_clr  (ovf_clr),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_ch    (ev_ch),
      .ev_rise  (ev_rise),
      .ovf      (ovf)
   );

   task automatic add(input logic [3:0] d, input logic [3:0] e, input logic [3:0] c,
                      input logic r, input logic v, input logic [1:0] ch,
                      input logic rs, input logic [3:0] o);
      vec_t t;
      t.din = d; t.en = e; t.clr = c; t.rdy = r;
      t.v = v; t.ch = ch; t.rise = rs; t.ovf = o;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input int step,
                        input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d actual=%0h required=%0h", name, step, act, exp);
      end
   endtask

   task automatic run_row(input int idx);
      vec_t t;
      t = vecs[idx];
      @(negedge clk);
      din = t.din; ch_en = t.en; ovf_clr = t.clr; ev_ready = t.rdy;
      @(posedge clk);
      #1;
      check("ev_valid", idx, 32'(ev_valid), 32'(t.v));
      check("ovf", idx, 32'(ovf), 32'(t.ovf));
      if (t.v) begin
         check("ev_ch", idx, 32'(ev_ch), 32'(t.ch));
         check("ev_rise", idx, 32'(ev_rise), 32'(t.rise));
      end
      $display("step %0d din=%b en=%b clr=%b rdy=%b -> valid=%b ch=%0d rise=%b ovf=%b",
               idx, t.din, t.en, t.clr, t.rdy, ev_valid, ev_ch, ev_rise, ovf);
   endtask

   initial begin
      //   din    en     clr   rdy   v     ch  rise  ovf
      // release with din high: arming swallows the reset-value edge
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      // din[2] falls: event two cycles later
      add(4'hB, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'hB, 4'hF, 4'h0, 1'b1, 1'b1, 2'd2, 1'b0, 4'h0);
      add(4'hB, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'h3, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'h3, 4'hF, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0, 4'h0);
      // ch0/ch1 fall while disabled: ignored, no stale edge on re-enable
      add(4'h0, 4'h8, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      // all rise together: 0,1,2,3 back to back
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 4'h0);
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 4'h0);
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 4'h0);
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 4'h0);
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      // backpressure: ch1 held, slot refilled, two further edges dropped
      add(4'hD, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'hD, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 4'h0);
      add(4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 4'h0);
      add(4'hD, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 4'h2);
      add(4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 4'h2);
      add(4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 4'h2);
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 4'h2);
      add(4'hF, 4'hF, 4'h2, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      // ch0 and ch3 toggling every cycle: grants alternate 3,0,3,0,...
      add(4'h6, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0, 4'h1);
      add(4'h6, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 4'h9);
      add(4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 4'h9);
      add(4'h6, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 4'h9);
      add(4'h6, 4'hF, 4'h0, 1'b1, 1'b1, 2'd3, 1'b1, 4'h9);
      add(4'h6, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 4'h9);
      add(4'h6, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h9);
      add(4'h6, 4'hF, 4'h9, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      // ch2 pending behind a busy output, then disabled: event dropped silently
      add(4'h2, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'h2, 4'hF, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0, 4'h0);
      add(4'h6, 4'hF, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0, 4'h0);
      add(4'h6, 4'hB, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0, 4'h0);
      add(4'h6, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'h6, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);
      add(4'h6, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0);

      // Reset asserted before any clock edge: values must appear asynchronously.
      #1 rst = 1'b1;
      #2;
      check("rst_valid", -1, 32'(ev_valid), 32'd0);
      check("rst_ch", -1, 32'(ev_ch), 32'd0);
      check("rst_rise", -1, 32'(ev_rise), 32'd0);
      check("rst_ovf", -1, 32'(ovf), 32'd0);
      $display("reset: valid=%b ch=%0d rise=%b ovf=%b", ev_valid, ev_ch, ev_rise, ovf);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         run_row(i);
      end

      // Mid-operation reset with an event held on the output.
      @(negedge clk);
      din = 4'h0; ev_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("pre_rst_valid", 100, 32'(ev_valid), 32'd1);
      $display("pre-reset: valid=%b ch=%0d rise=%b", ev_valid, ev_ch, ev_rise);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 101, 32'(ev_valid), 32'd0);
      check("async_rst_ch", 101, 32'(ev_ch), 32'd0);
      $display("mid reset: valid=%b ch=%0d", ev_valid, ev_ch);
      @(negedge clk);
      rst = 1'b0; ev_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("post_rst_quiet", 102 + i, 32'(ev_valid), 32'd0);
         $display("post-reset cycle %0d: valid=%b ovf=%b", i, ev_valid, ovf);
      end

      // A fresh edge after reset still gets through with the usual latency.
      @(negedge clk);
      din = 4'h1;
      @(posedge clk);
      #1;
      check("fresh_early", 110, 32'(ev_valid), 32'd0);
      @(posedge clk);
      #1;
      check("fresh_valid", 111, 32'(ev_valid), 32'd1);
      check("fresh_ch", 111, 32'(ev_ch), 32'd0);
      check("fresh_rise", 111, 32'(ev_rise), 32'd1);
      $display("fresh edge: valid=%b ch=%0d rise=%b", ev_valid, ev_ch, ev_rise);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
